// File: rtl/bus_pkg.sv
// Shared constants, state encoding and owner type for the two-requester bus arbiter.
package bus_pkg;

    localparam int unsigned ADDR_W_DEF = 20;
    localparam int unsigned DATA_W_DEF = 16;
    localparam int unsigned WAIT_W     = 4;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    typedef logic owner_t;

    localparam owner_t OWNER_CPU = 1'b0;
    localparam owner_t OWNER_DMA = 1'b1;

endpackage

// File: rtl/bus_arb_pick.sv
// Combinational grant selection between CPU (0) and DMA/IO (1).
// BUS_ARBITER_ROUND_ROBIN_EN: defined = alternate on contention, undefined = CPU always wins.
module bus_arb_pick
    import bus_pkg::*;
(
    input  logic req0,
    input  logic req1,
`ifdef BUS_ARBITER_ROUND_ROBIN_EN
    input  logic last_owner,
`endif
    output logic grant_valid,
    output logic grant
);

    always_comb begin
        grant_valid = req0 | req1;
        grant       = OWNER_CPU;
`ifdef BUS_ARBITER_ROUND_ROBIN_EN
        if (req0 && req1) begin
            grant = ~last_owner;
        end else if (req1) begin
            grant = OWNER_DMA;
        end
`else
        if (!req0 && req1) begin
            grant = OWNER_DMA;
        end
`endif
    end

endmodule

// File: rtl/bus_arbiter.sv
// Two-requester shared-bus arbiter with IDLE/ACCESS/DONE sequencing and a tri-state data bus.
// Arbitration policy selected by BUS_ARBITER_ROUND_ROBIN_EN (see bus_arb_pick).
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int unsigned ADDR_W      = ADDR_W_DEF,
    parameter int unsigned DATA_W      = DATA_W_DEF,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] bus_addr,
    inout  wire  [DATA_W-1:0] bus_data,
    output logic              read,
    output logic              write
);

    logic [1:0]        state;
    owner_t            owner;
    logic              we_l;
    logic [ADDR_W-1:0] addr_l;
    logic [DATA_W-1:0] wdata_l;
    logic [WAIT_W-1:0] wait_cnt;

    logic              grant_valid;
    logic              grant;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              in_access;

`ifdef BUS_ARBITER_ROUND_ROBIN_EN
    owner_t last_owner;
`endif

    bus_arb_pick u_pick (
        .req0       (req0),
        .req1       (req1),
`ifdef BUS_ARBITER_ROUND_ROBIN_EN
        .last_owner (last_owner),
`endif
        .grant_valid(grant_valid),
        .grant      (grant)
    );

    always_comb begin
        sel_we    = we0;
        sel_addr  = addr0;
        sel_wdata = wdata0;
        if (grant == OWNER_DMA) begin
            sel_we    = we1;
            sel_addr  = addr1;
            sel_wdata = wdata1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            owner    <= OWNER_CPU;
            we_l     <= 1'b0;
            addr_l   <= '0;
            wdata_l  <= '0;
            wait_cnt <= '0;
            rdata    <= '0;
`ifdef BUS_ARBITER_ROUND_ROBIN_EN
            last_owner <= OWNER_DMA;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant_valid) begin
                        owner    <= grant;
                        we_l     <= sel_we;
                        addr_l   <= sel_addr;
                        wdata_l  <= sel_wdata;
                        wait_cnt <= WAIT_W'(WAIT_CYCLES);
                        state    <= ST_ACCESS;
`ifdef BUS_ARBITER_ROUND_ROBIN_EN
                        last_owner <= grant;
`endif
                    end
                end
                ST_ACCESS: begin
                    if (wait_cnt != '0) begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end else begin
                        if (!we_l) begin
                            rdata <= bus_data;
                        end
                        state <= ST_DONE;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Bus outputs decode straight from state so an async reset releases them at once.
    assign in_access = (state == ST_ACCESS);
    assign bus_addr  = in_access ? addr_l : '0;
    assign read      = in_access & ~we_l;
    assign write     = in_access & we_l;
    assign bus_data  = write ? wdata_l : 'z;
    assign ack0      = (state == ST_DONE) && (owner == OWNER_CPU);
    assign ack1      = (state == ST_DONE) && (owner == OWNER_DMA);

endmodule
